// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the command frame parser:
//   - command letter codes understood by the VM command handler
//   - parser state encoding
//   - argument-length encoding (LEN_UNKNOWN marks a byte that is not a command)
// No ports (package).
// -----------------------------------------------------------------------------
package cmd_pkg;

    // Commands carrying an argument
    localparam logic [7:0] CMD_ADDR_W = 8'h41; // 'A', 2-byte argument
    localparam logic [7:0] CMD_BUS_W  = 8'h42; // 'B', 1-byte argument
    localparam logic [7:0] CMD_OFF    = 8'h4F; // 'O', 4-byte argument
    localparam logic [7:0] CMD_MCW    = 8'h4D; // 'M', 4-byte argument
    localparam logic [7:0] CMD_OPC    = 8'h72; // 'r', 4-byte argument

    // Commands without an argument
    localparam logic [7:0] CMD_UC_I   = 8'h49; // 'I'
    localparam logic [7:0] CMD_LC_A   = 8'h61; // 'a'
    localparam logic [7:0] CMD_LC_B   = 8'h62; // 'b'
    localparam logic [7:0] CMD_LC_S   = 8'h73; // 's'
    localparam logic [7:0] CMD_LC_F   = 8'h66; // 'f'
    localparam logic [7:0] CMD_UC_N   = 8'h4E; // 'N'
    localparam logic [7:0] CMD_LC_C   = 8'h63; // 'c'
    localparam logic [7:0] CMD_UC_C   = 8'h43; // 'C'
    localparam logic [7:0] CMD_UC_T   = 8'h54; // 'T'
    localparam logic [7:0] CMD_UC_R   = 8'h52; // 'R'
    localparam logic [7:0] CMD_UC_Z   = 8'h5A; // 'Z'
    localparam logic [7:0] CMD_UC_Q   = 8'h51; // 'Q'
    // Read-timeout NOP; also accepted on the wire as a zero-length command
    localparam logic [7:0] CMD_NOP_TO = 8'hFF;

    // Argument-length encoding
    localparam logic [2:0] LEN_0       = 3'd0;
    localparam logic [2:0] LEN_1       = 3'd1;
    localparam logic [2:0] LEN_2       = 3'd2;
    localparam logic [2:0] LEN_4       = 3'd4;
    localparam logic [2:0] LEN_UNKNOWN = 3'b111;

    // Parser states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        EMIT = 2'd2
    } state_e;

endpackage

// File: rtl/cmd_arg_decoder.sv
// -----------------------------------------------------------------------------
// cmd_arg_decoder
// Combinational lookup from a command byte to its argument length.
// Ports:
//   cmd_i  in  8  candidate command byte
//   len_o  out 3  argument length in bytes (0/1/2/4), LEN_UNKNOWN if not a command
// -----------------------------------------------------------------------------
module cmd_arg_decoder
    import cmd_pkg::*;
(
    input  logic [7:0] cmd_i,
    output logic [2:0] len_o
);

    always_comb begin
        len_o = LEN_UNKNOWN;
        case (cmd_i)
            CMD_ADDR_W:                    len_o = LEN_2;
            CMD_BUS_W:                     len_o = LEN_1;
            CMD_OFF, CMD_MCW, CMD_OPC:     len_o = LEN_4;
            CMD_UC_I, CMD_LC_A, CMD_LC_B,
            CMD_LC_S, CMD_LC_F, CMD_UC_N,
            CMD_LC_C, CMD_UC_C, CMD_UC_T,
            CMD_UC_R, CMD_UC_Z, CMD_UC_Q,
            CMD_NOP_TO:                    len_o = LEN_0;
            default:                       len_o = LEN_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/cmd_frame_parser.sv
// -----------------------------------------------------------------------------
// cmd_frame_parser
// Frames a raw byte stream into {command letter, little-endian argument}
// records and hands them to the VM command handler over valid/ready.
//
// Optional feature: define ARG_TIMEOUT_EN to abort a stalled argument after
// TIMEOUT_CYCLES idle cycles and emit a NOP record (cmd_out = 8'hFF).
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous active-high reset
//   rx_data      in   8   incoming byte
//   rx_valid     in   1   rx_data valid
//   rx_ready     out  1   byte accepted when rx_valid && rx_ready
//   cmd_out      out  8   command letter, or 8'hFF for a timeout NOP
//   arg_out      out  32  argument, zero-extended
//   arg_len      out  3   argument bytes received (0/1/2/4)
//   cmd_valid    out  1   record valid
//   cmd_ready    in   1   handler consumes the record
//   err_unknown  out  1   one-cycle pulse per dropped unknown command byte
//   busy         out  1   parser not in IDLE
// -----------------------------------------------------------------------------
module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  cmd_out,
    output logic [31:0] arg_out,
    output logic [2:0]  arg_len,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        err_unknown,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [2:0]  arg_len_q, arg_len_d;
    logic [2:0]  exp_len_q, exp_len_d;   // length expected for the current frame
    logic [1:0]  idx_q, idx_d;           // index of the next argument byte
    logic        err_q, err_d;
    logic [2:0]  dec_len;
    logic        rx_fire;

`ifdef ARG_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_d;
`else
    // Timeout configuration is intentionally unused in this build
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0) && (TO_W > 0);
`endif

    cmd_arg_decoder u_dec (
        .cmd_i (rx_data),
        .len_o (dec_len)
    );

    // EMIT is the only state that refuses bytes, so rx_ready and cmd_valid
    // are mutually exclusive by construction.
    assign rx_ready    = (state_q != EMIT);
    assign cmd_valid   = (state_q == EMIT);
    assign busy        = (state_q != IDLE);
    assign rx_fire     = rx_valid && rx_ready;
    assign cmd_out     = cmd_q;
    assign arg_out     = arg_q;
    assign arg_len     = arg_len_q;
    assign err_unknown = err_q;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        arg_len_d = arg_len_q;
        exp_len_d = exp_len_q;
        idx_d     = idx_q;
        err_d     = 1'b0;
`ifdef ARG_TIMEOUT_EN
        to_d      = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    if (dec_len == LEN_UNKNOWN) begin
                        err_d = 1'b1;
                    end else begin
                        cmd_d     = rx_data;
                        arg_d     = '0;
                        arg_len_d = LEN_0;
                        exp_len_d = dec_len;
                        idx_d     = 2'd0;
`ifdef ARG_TIMEOUT_EN
                        to_d      = '0;
`endif
                        state_d   = (dec_len == LEN_0) ? EMIT : ARG;
                    end
                end
            end
            ARG: begin
                if (rx_fire) begin
                    arg_d[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
`ifdef ARG_TIMEOUT_EN
                    to_d  = '0;
`endif
                    if ({1'b0, idx_q} + 3'd1 == exp_len_q) begin
                        arg_len_d = exp_len_q;
                        state_d   = EMIT;
                    end
                end
`ifdef ARG_TIMEOUT_EN
                // The TIMEOUT_CYCLES-th consecutive idle cycle aborts the frame
                else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    cmd_d     = CMD_NOP_TO;
                    arg_d     = '0;
                    arg_len_d = LEN_0;
                    to_d      = '0;
                    state_d   = EMIT;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
`endif
            end
            EMIT: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            arg_q     <= '0;
            arg_len_q <= '0;
            exp_len_q <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
`ifdef ARG_TIMEOUT_EN
            to_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            arg_len_q <= arg_len_d;
            exp_len_q <= exp_len_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
`ifdef ARG_TIMEOUT_EN
            to_q      <= to_d;
`endif
        end
    end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_parser
// Directed and randomized checks of cmd_frame_parser against a command-table
// reference model. Inputs change 1 time unit after the rising edge; outputs are
// observed at that same point, i.e. well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_cmd_frame_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  cmd_out;
    logic [31:0] arg_out;
    logic [2:0]  arg_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        err_unknown;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cmd_frame_parser #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cmd_out     (cmd_out),
        .arg_out     (arg_out),
        .arg_len     (arg_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .err_unknown (err_unknown),
        .busy        (busy)
    );

    // Reference command table: argument bytes per command, -1 if not a command
    function automatic int ref_len(input logic [7:0] c);
        case (c)
            "A":                          return 2;
            "B":                          return 1;
            "O", "M", "r":                return 4;
            "I", "a", "b", "s", "f", "N",
            "c", "C", "T", "R", "Z", "Q",
            8'hFF:                        return 0;
            default:                      return -1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and hold it until it is accepted (bounded wait)
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            tick();
            n++;
        end
        if (!rx_ready) check("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic expect_record(input string tag, input logic [7:0] c,
                                 input logic [31:0] a, input logic [2:0] l);
        check({tag, "_valid"}, {31'b0, cmd_valid}, 32'd1);
        check({tag, "_cmd"},   {24'b0, cmd_out},   {24'b0, c});
        check({tag, "_arg"},   arg_out,            a);
        check({tag, "_len"},   {29'b0, arg_len},   {29'b0, l});
        check({tag, "_rxrdy"}, {31'b0, rx_ready},  32'd0);
    endtask

    task automatic release_record(input string tag);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check({tag, "_drop_valid"}, {31'b0, cmd_valid}, 32'd0);
        check({tag, "_idle"},       {31'b0, busy},      32'd0);
    endtask

    logic [7:0] known_cmds [18] = '{"A", "B", "O", "M", "r", "I", "a", "b", "s",
                                    "f", "N", "c", "C", "T", "R", "Z", "Q", 8'hFF};

    initial begin
        logic [7:0]  c, b;
        logic [31:0] exp_arg;
        int          len, hold, gap;

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_rx_ready",  {31'b0, rx_ready},    32'd1);
        check("rst_cmd_valid", {31'b0, cmd_valid},   32'd0);
        check("rst_cmd_out",   {24'b0, cmd_out},     32'd0);
        check("rst_arg_out",   arg_out,              32'd0);
        check("rst_arg_len",   {29'b0, arg_len},     32'd0);
        check("rst_err",       {31'b0, err_unknown}, 32'd0);
        check("rst_busy",      {31'b0, busy},        32'd0);
        rst = 1'b0;
        tick();

        // 'A' 0x34 0x12: record visible the cycle after the last byte
        send_byte("A");
        check("a_busy", {31'b0, busy}, 32'd1);
        check("a_no_valid", {31'b0, cmd_valid}, 32'd0);
        send_byte(8'h34);
        send_byte(8'h12);
        expect_record("a", 8'h41, 32'h0000_1234, 3'd2);
        release_record("a");

        // 'M' with the handler stalling for 5 cycles
        send_byte("M");
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        expect_record("m", 8'h4D, 32'hDEAD_BEEF, 3'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("m_hold_arg",   arg_out,              32'hDEAD_BEEF);
            check("m_hold_valid", {31'b0, cmd_valid},   32'd1);
            check("m_hold_rxrdy", {31'b0, rx_ready},    32'd0);
        end
        release_record("m");

        // Unknown 'X' then 'T'
        send_byte("X");
        check("x_err_pulse", {31'b0, err_unknown}, 32'd1);
        check("x_no_valid",  {31'b0, cmd_valid},   32'd0);
        check("x_idle",      {31'b0, busy},        32'd0);
        tick();
        check("x_err_end",   {31'b0, err_unknown}, 32'd0);
        check("x_no_valid2", {31'b0, cmd_valid},   32'd0);
        send_byte("T");
        check("t_no_err", {31'b0, err_unknown}, 32'd0);
        expect_record("t", 8'h54, 32'd0, 3'd0);
        release_record("t");

        // Reset mid-frame discards 'O' 0x01 0x02
        send_byte("O"); send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_valid", {31'b0, cmd_valid},   32'd0);
        check("rstmid_err",   {31'b0, err_unknown}, 32'd0);
        check("rstmid_busy",  {31'b0, busy},        32'd0);
        tick();
        check("rstmid_valid2", {31'b0, cmd_valid},  32'd0);
        send_byte("c");
        expect_record("c", 8'h63, 32'd0, 3'd0);
        release_record("c");

        // Back-to-back 'B' 0x7F then 'R' with cmd_ready tied high
        cmd_ready = 1'b1;
        send_byte("B");
        send_byte(8'h7F);
        expect_record("b2b_b", 8'h42, 32'h0000_007F, 3'd1);
        tick();
        check("b2b_b_1cyc", {31'b0, cmd_valid}, 32'd0);
        check("b2b_rxrdy",  {31'b0, rx_ready},  32'd1);
        send_byte("R");
        expect_record("b2b_r", 8'h52, 32'd0, 3'd0);
        tick();
        check("b2b_r_1cyc", {31'b0, cmd_valid}, 32'd0);
        cmd_ready = 1'b0;

        // Stalled argument
        send_byte("A");
        send_byte(8'h10);
`ifdef ARG_TIMEOUT_EN
        repeat (7) tick();
        check("to_not_yet", {31'b0, cmd_valid}, 32'd0);
        tick();
        expect_record("to_nop", 8'hFF, 32'd0, 3'd0);
        release_record("to_nop");
`else
        repeat (100) tick();
        check("to_none_valid", {31'b0, cmd_valid}, 32'd0);
        check("to_none_busy",  {31'b0, busy},      32'd1);
        send_byte(8'h34);
        expect_record("to_resume", 8'h41, 32'h0000_3410, 3'd2);
        release_record("to_resume");
`endif

        // Randomized frames, occasionally preceded by an unknown byte
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                do b = 8'($urandom_range(0, 255)); while (ref_len(b) >= 0);
                send_byte(b);
                check("rnd_err", {31'b0, err_unknown}, 32'd1);
                tick();
            end
            c   = known_cmds[$urandom_range(0, 17)];
            len = ref_len(c);
            exp_arg = '0;
            send_byte(c);
            for (int k = 0; k < len; k++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) tick();
                b = 8'($urandom_range(0, 255));
                exp_arg = exp_arg | (32'(b) << (8 * k));
                send_byte(b);
            end
            expect_record("rnd", c, exp_arg, 3'(len));
            hold = $urandom_range(0, 3);
            repeat (hold) tick();
            check("rnd_hold_arg", arg_out, exp_arg);
            release_record("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
